pixel_array_readout: RTL
========================

# pixel_array_readout

Parametrised digital back-end for the pixel array: drives a shared single-slope ADC ramp counter, latches one count per pixel when that pixel's comparator trips, then streams the array out row by row over a valid/ready interface. It generalises the 2×2, fixed-8-bit, two-read-strobe array to N_ROWS × N_COLS pixels with configurable ADC resolution and backpressure-aware readout. It sits between the analog pixel/comparator array and the frame-capture logic.

## Interface
- N_ROWS, default 2, pixel rows (≥1)
- N_COLS, default 2, pixel columns (≥1)
- ADC_BITS, default 8, counter and per-pixel result width (2..12)
- clk  input  1  single clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- START  input  1  begin a frame conversion; honoured only in IDLE
- CMP  input  N_ROWS*N_COLS  per-pixel comparator outputs, bit r*N_COLS+c; already synchronous to clk
- RAMP_EN  output  1  ramp active (analog DAC enable)
- CNT  output  ADC_BITS  current ramp code, drives DAC
- CDS_PHASE  output  1  0 = reset-level conversion, 1 = signal-level (constant 1 without CDS)
- BUSY  output  1  high in every state except IDLE
- OUT_VALID  output  1  row data available
- OUT_READY  input  1  consumer accepts row
- OUT_ROW  output  $clog2(N_ROWS) (min 1)  index of row on OUT_DATA
- OUT_DATA  output  N_COLS*ADC_BITS  column c in bits [c*ADC_BITS +: ADC_BITS]
- DONE  output  1  one-cycle pulse after last row accepted

## Operation
- States: IDLE, CONV_RST (CDS only), CONV_SIG, READOUT.
- IDLE: START=1 → CONV_RST if CDS built, else CONV_SIG. Latch arrays and per-pixel "tripped" flags cleared on that transition.
- CONV_*: RAMP_EN=1; CNT starts at 0, increments by 1 each cycle. Each cycle, every pixel whose tripped flag is 0 and CMP bit is 1 stores the current CNT and sets its flag; later CMP activity for that pixel is ignored. Cycle with CNT = 2^ADC_BITS−1 is the last: untripped pixels store 2^ADC_BITS−1. Then CONV_RST → CONV_SIG (CNT back to 0, flags cleared, reset values retained), CONV_SIG → READOUT.
- READOUT: OUT_VALID=1, OUT_ROW starts at 0, OUT_DATA = that row's results. OUT_ROW/OUT_DATA stable while OUT_VALID && !OUT_READY. On VALID&&READY: advance row; after row N_ROWS−1, DONE=1 for one cycle, state IDLE, OUT_VALID=0.
- START outside IDLE ignored (no queueing).
- Result width = ADC_BITS; no arithmetic beyond CDS subtract.

## Timing
- Reset values: RAMP_EN=0, CNT=0, CDS_PHASE=0, BUSY=0, OUT_VALID=0, OUT_ROW=0, OUT_DATA=0, DONE=0; state IDLE; all latches and flags 0.
- reset_n low mid-operation: immediate return to reset values; no DONE, partial frame discarded.
- START sampled at cycle k → cycle k+1: BUSY=1, RAMP_EN=1, CNT=0.
- Conversion phase = 2^ADC_BITS cycles exactly; CMP sampled same edge as CNT value shown → pixel tripping while CNT=n stores n.
- First OUT_VALID in cycle after last conversion cycle; RAMP_EN=0 from that cycle.
- Readout minimum N_ROWS cycles with OUT_READY held high; DONE coincides with the cycle after the last accepted row (state IDLE, BUSY=0 same cycle).
- Frame minimum (no CDS): 1 + 2^ADC_BITS + N_ROWS cycles from START to DONE.

## Configuration
- PIXEL_ARRAY_CDS_EN defined: correlated double sampling. Two conversions per frame (CONV_RST with CDS_PHASE=0, CONV_SIG with CDS_PHASE=1); second latch array kept; OUT_DATA per pixel = sig − rst, saturated to 0 if negative. Frame length +2^ADC_BITS cycles.
- Undefined: single conversion, no reset-level storage, CDS_PHASE tied 1, OUT_DATA = raw latched count.

## Test plan
- Defaults, no CDS: CMP bits [0..3] rise at CNT 0x30, 0x31, 0x32, 0x33 → rows read out {0x31,0x30} then {0x33,0x32} (col1,col0); DONE 1+256+2 cycles after START.
- Pixel 3 never trips, pixel 0 high from start → pixel0=0x00, pixel3=0xFF.
- OUT_READY held low 5 cycles on row 0 → OUT_DATA/OUT_ROW stable, no DONE; release → row 1, then DONE.
- START pulsed during CONV_SIG and READOUT → ignored, single DONE; reset_n low at CNT=0x80 → all outputs reset values, next START converts normally.
- CDS build: reset trips at 0x10, signal at 0x50 → 0x40; reset 0x60, signal 0x20 → 0x00.
- N_ROWS=4, N_COLS=3, ADC_BITS=4: 16-cycle ramps, 4 rows OUT_ROW 0..3, 12-bit OUT_DATA packing correct.

Source files
------------

// File: rtl/pixel_array_readout_if.sv
// Row readout channel of pixel_array_readout: valid/ready row stream plus end-of-frame pulse.
// The master side is the readout block; the slave side is the frame-capture consumer.
interface pixel_array_readout_if #(
  parameter int N_ROWS   = 2,
  parameter int N_COLS   = 2,
  parameter int ADC_BITS = 8
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic                       OUT_VALID;
  logic                       OUT_READY;
  logic [ROW_W-1:0]           OUT_ROW;
  logic [N_COLS*ADC_BITS-1:0] OUT_DATA;
  logic                       DONE;

  modport master (
    output OUT_VALID,
    output OUT_ROW,
    output OUT_DATA,
    output DONE,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_ROW,
    input  OUT_DATA,
    input  DONE,
    output OUT_READY
  );
endinterface

// File: rtl/pixel_array_readout.sv
// Single-slope ADC back-end for an N_ROWS x N_COLS pixel array with row-by-row valid/ready readout.
// Define PIXEL_ARRAY_CDS_EN to build correlated double sampling (reset + signal conversion, sig - rst).
module pixel_array_readout #(
  parameter int N_ROWS   = 2,
  parameter int N_COLS   = 2,
  parameter int ADC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       START,
  input  logic [N_ROWS*N_COLS-1:0]   CMP,
  output logic                       RAMP_EN,
  output logic [ADC_BITS-1:0]        CNT,
  output logic                       CDS_PHASE,
  output logic                       BUSY,
  pixel_array_readout_if.master      rd
);

  localparam int NPIX  = N_ROWS * N_COLS;
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [ADC_BITS-1:0] CNT_MAX  = '1;
  localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(N_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV_RST,
    CONV_SIG,
    READOUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADC_BITS-1:0]            cnt;
  logic [ROW_W-1:0]               row;
  logic                           done_q;
  logic [NPIX-1:0]                tripped;
  logic [NPIX-1:0][ADC_BITS-1:0]  sig_lat;
`ifdef PIXEL_ARRAY_CDS_EN
  logic [NPIX-1:0][ADC_BITS-1:0]  rst_lat;
`endif
  logic [N_COLS*ADC_BITS-1:0]     out_data;

  logic conv;
  logic last_cnt;
  logic frame_start;
  logic accept;
  logic last_row;

  assign conv        = (state == CONV_RST) || (state == CONV_SIG);
  assign last_cnt    = (cnt == CNT_MAX);
  assign frame_start = (state == IDLE) && START;
  assign accept      = (state == READOUT) && rd.OUT_READY;
  assign last_row    = (row == LAST_ROW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (START) begin
`ifdef PIXEL_ARRAY_CDS_EN
          state_nxt = CONV_RST;
`else
          state_nxt = CONV_SIG;
`endif
        end
      end
      CONV_RST: begin
        if (last_cnt) begin
          state_nxt = CONV_SIG;
        end
      end
      CONV_SIG: begin
        if (last_cnt) begin
          state_nxt = READOUT;
        end
      end
      READOUT: begin
        if (accept && last_row) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ramp code wraps to 0 naturally at the end of each phase; row index walks on each accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      row    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt    <= conv ? cnt + 1'b1 : '0;
      if (state != READOUT) begin
        row <= '0;
      end else if (accept) begin
        if (last_row) begin
          row    <= '0;
          done_q <= 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

  // First comparator trip wins; pixels still untripped on the final code latch full scale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tripped <= '0;
      sig_lat <= '0;
`ifdef PIXEL_ARRAY_CDS_EN
      rst_lat <= '0;
`endif
    end else if (frame_start) begin
      tripped <= '0;
      sig_lat <= '0;
`ifdef PIXEL_ARRAY_CDS_EN
      rst_lat <= '0;
`endif
    end else if (conv) begin
      for (int p = 0; p < NPIX; p++) begin
        if (!tripped[p] && (CMP[p] || last_cnt)) begin
          tripped[p] <= 1'b1;
`ifdef PIXEL_ARRAY_CDS_EN
          if (state == CONV_RST) begin
            rst_lat[p] <= cnt;
          end else begin
            sig_lat[p] <= cnt;
          end
`else
          sig_lat[p] <= cnt;
`endif
        end
      end
      if (last_cnt) begin
        tripped <= '0;
      end
    end
  end

  always_comb begin
    int unsigned base;
    out_data = '0;
    base     = 0;
    if (state == READOUT) begin
      base = int'(row) * N_COLS;
      for (int c = 0; c < N_COLS; c++) begin
`ifdef PIXEL_ARRAY_CDS_EN
        if (sig_lat[base + c] >= rst_lat[base + c]) begin
          out_data[c*ADC_BITS +: ADC_BITS] = sig_lat[base + c] - rst_lat[base + c];
        end else begin
          out_data[c*ADC_BITS +: ADC_BITS] = '0;
        end
`else
        out_data[c*ADC_BITS +: ADC_BITS] = sig_lat[base + c];
`endif
      end
    end
  end

  assign RAMP_EN = conv;
  assign CNT     = cnt;
  assign BUSY    = (state != IDLE);
`ifdef PIXEL_ARRAY_CDS_EN
  assign CDS_PHASE = (state == CONV_SIG);
`else
  assign CDS_PHASE = 1'b1;
`endif

  assign rd.OUT_VALID = (state == READOUT);
  assign rd.OUT_ROW   = row;
  assign rd.OUT_DATA  = out_data;
  assign rd.DONE      = done_q;

endmodule
